// File: rtl/alu_isa_pkg.sv
// rtl/alu_isa_pkg.sv - ALU instruction word layout, opcode constants and encode helpers
package alu_isa_pkg;

    localparam int INST_W = 32;
    localparam int OP_W   = 4;
    localparam int REG_W  = 6;
    localparam int IMM_W  = 16;

    localparam int RI_POS  = 31;
    localparam int OP_MSB  = 30;
    localparam int OP_LSB  = 27;
    localparam int RS_MSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RD_MSB  = 20;
    localparam int RD_LSB  = 15;
    localparam int RT_MSB  = 14;
    localparam int RT_LSB  = 9;
    localparam int IMM_MSB = 14;
    localparam int IMM_LSB = 0;

    localparam int IMM_MIN = -16384;
    localparam int IMM_MAX = 16383;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_e;

    // The 16-bit immediate only fits the 15-bit field when its top two bits agree
    function automatic logic imm_fits(logic [IMM_W-1:0] imm);
        return imm[IMM_W-1] == imm[IMM_W-2];
    endfunction

    function automatic logic [INST_W-1:0] encode(
        logic                 ri,
        logic [OP_W-1:0]      op,
        logic [REG_W-1:0]     rs,
        logic [REG_W-1:0]     rd,
        logic [REG_W-1:0]     rt,
        logic [IMM_MSB:0]     imm15
    );
        logic [INST_W-1:0] w;
        w                 = '0;
        w[RI_POS]         = ri;
        w[OP_MSB:OP_LSB]  = op;
        w[RS_MSB:RS_LSB]  = rs;
        w[RD_MSB:RD_LSB]  = rd;
        if (ri) begin
            w[IMM_MSB:IMM_LSB] = imm15;
        end else begin
            w[RT_MSB:RT_LSB] = rt;
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - circular word buffer with push/pop/flush and occupancy
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign level   = count;
    // Stale storage is hidden so the output reads zero whenever nothing is buffered
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - field bundle to 32-bit ALU word encoder with output buffer; INST_ENCODER_STATS_EN adds acc_cnt/rej_cnt
module inst_encoder
    import alu_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     ri,
    input  logic [OP_W-1:0]          alu_op,
    input  logic [REG_W-1:0]         rs,
    input  logic [REG_W-1:0]         rd,
    input  logic [REG_W-1:0]         rt,
    input  logic [IMM_W-1:0]         imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_W-1:0]        inst,
    input  logic                     flush,
    output logic                     err,
`ifdef INST_ENCODER_STATS_EN
    output logic [15:0]              acc_cnt,
    output logic [15:0]              rej_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    logic              accept;
    logic              reject;
    logic              push;
    logic              empty;
    logic              full;
    logic [INST_W-1:0] word;

    assign in_ready  = ~full & ~flush;
    assign accept    = in_valid & in_ready;
    // Out-of-range immediates are consumed (handshake completes) but never buffered
    assign reject    = accept & ri & ~imm_fits(imm);
    assign push      = accept & ~reject;
    assign word      = encode(ri, alu_op, rs, rd, rt, imm[IMM_MSB:0]);
    assign out_valid = ~empty;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (out_ready),
        .flush (flush),
        .wdata (word),
        .rdata (inst),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= reject;
        end
    end

`ifdef INST_ENCODER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else begin
            if (push && acc_cnt != 16'hFFFF) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (reject && rej_cnt != 16'hFFFF) begin
                rej_cnt <= rej_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
